// File: rtl/gesture_issuer.sv
// Round sequencer for the score grader: countdown, gesture latch, start strobe, win check.
// All outputs are registered and cleared asynchronously by sw2.
module gesture_issuer #(
    parameter int unsigned BEAT_CYCLES  = 50_000_000,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned WIN_SCORE    = 3
) (
    input  logic       clk,
    input  logic       sw2,
    input  logic       go,
    input  logic [2:0] btn_left,
    input  logic [2:0] btn_right,
    input  logic [2:0] a_score,
    input  logic [2:0] b_score,
    output logic [2:0] left,
    output logic [2:0] right,
    output logic       start_pulse,
    output logic [1:0] beat,
    output logic       busy,
    output logic       match_over
);

    localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BEAT_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [2:0]    WIN        = 3'(WIN_SCORE);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StSetup,
        StPulse,
        StSettle,
        StDone
    } state_e;

    state_e        state;
    logic [BW-1:0] beat_cnt;
    logic [PW-1:0] pulse_cnt;
    logic          go_d;
    logic          go_edge;

    assign go_edge = go & ~go_d;

    // Anything other than a single pressed button counts as no show.
    function automatic logic [2:0] sanitize(input logic [2:0] b);
        case (b)
            3'b001, 3'b010, 3'b100: return b;
            default:                return 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge sw2) begin
        if (sw2) begin
            state       <= StIdle;
            beat_cnt    <= '0;
            pulse_cnt   <= '0;
            go_d        <= 1'b1;
            left        <= 3'b000;
            right       <= 3'b000;
            start_pulse <= 1'b0;
            beat        <= 2'd0;
            busy        <= 1'b0;
            match_over  <= 1'b0;
        end else begin
            go_d <= go;
            unique case (state)
                StIdle: begin
                    if (go_edge) begin
                        state    <= StCount;
                        beat     <= 2'd3;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                StCount: begin
                    if (beat_cnt == BEAT_LAST) begin
                        beat_cnt <= '0;
                        beat     <= beat - 2'd1;
                        if (beat == 2'd1) begin
                            state <= StSetup;
                            left  <= sanitize(btn_left);
                            right <= sanitize(btn_right);
                        end
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                StSetup: begin
                    state       <= StPulse;
                    start_pulse <= 1'b1;
                    pulse_cnt   <= '0;
                end
                StPulse: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        start_pulse <= 1'b0;
                        state       <= StSettle;
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end
                StSettle: begin
                    busy <= 1'b0;
                    if (a_score >= WIN || b_score >= WIN) begin
                        state      <= StDone;
                        match_over <= 1'b1;
                    end else begin
                        state <= StIdle;
                    end
                end
                StDone: begin
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_issuer.sv
// Scoreboard bench for gesture_issuer: expected gestures are queued per round and
// compared when start_pulse rises; per-cycle timing is checked against the round schedule.
module tb_gesture_issuer;

    logic       clk = 1'b0;
    logic       sw2;
    logic       go;
    logic [2:0] btn_left;
    logic [2:0] btn_right;
    logic [2:0] a_score;
    logic [2:0] b_score;
    logic [2:0] left;
    logic [2:0] right;
    logic       start_pulse;
    logic [1:0] beat;
    logic       busy;
    logic       match_over;

    int n_checks = 0;
    int n_fail   = 0;
    logic [5:0] sb_q[$];

    gesture_issuer #(
        .BEAT_CYCLES (4),
        .PULSE_CYCLES(2),
        .WIN_SCORE   (3)
    ) dut (
        .clk        (clk),
        .sw2        (sw2),
        .go         (go),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .a_score    (a_score),
        .b_score    (b_score),
        .left       (left),
        .right      (right),
        .start_pulse(start_pulse),
        .beat       (beat),
        .busy       (busy),
        .match_over (match_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] gest(input logic [2:0] b);
        if (b == 3'b001 || b == 3'b010 || b == 3'b100) return b;
        return 3'b000;
    endfunction

    // Every strobe must correspond to a queued round and carry its latched gestures.
    always @(posedge start_pulse) begin
        logic [5:0] e;
        if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'(start_pulse), 0);
        end else begin
            e = sb_q.pop_front();
            check("pulse_left", 32'(left), 32'(e[5:3]));
            check("pulse_right", 32'(right), 32'(e[2:0]));
        end
    end

    // Runs one round from the edge before E through E+last_k, checking each cycle.
    task automatic do_round(input logic [2:0] bl, input logic [2:0] br,
                            input logic [2:0] late_l, input logic [2:0] late_r,
                            input bit extra_go, input logic [2:0] asc, input int last_k);
        logic [2:0] el;
        logic [2:0] er;
        int         eb;
        bit         win;
        el = gest(bl);
        er = gest(br);
        win = (asc >= 3'd3);
        btn_left = bl;
        btn_right = br;
        a_score = 3'd0;
        go = 1'b0;
        @(posedge clk); #1;
        go = 1'b1;
        sb_q.push_back({el, er});
        @(posedge clk); #1;
        check("beat_E", 32'(beat), 3);
        check("busy_E", 32'(busy), 1);
        for (int k = 1; k <= last_k; k++) begin
            if (k == 1) go = 1'b0;
            if (extra_go && k == 5) go = 1'b1;
            if (k == 14) begin
                btn_left = late_l;
                btn_right = late_r;
            end
            if (k == 15) a_score = asc;
            @(posedge clk); #1;
            eb = (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
            check("beat", 32'(beat), eb);
            check("start_pulse", 32'(start_pulse), (k == 13 || k == 14) ? 1 : 0);
            check("busy", 32'(busy), (k < 16) ? 1 : 0);
            check("match_over", 32'(match_over), (k >= 16 && win) ? 1 : 0);
            if (k >= 12) begin
                check("left", 32'(left), 32'(el));
                check("right", 32'(right), 32'(er));
            end
        end
    endtask

    initial begin
        sw2 = 1'b1;
        go = 1'b1;
        btn_left = 3'd0;
        btn_right = 3'd0;
        a_score = 3'd0;
        b_score = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_left", 32'(left), 0);
        check("rst_right", 32'(right), 0);
        check("rst_pulse", 32'(start_pulse), 0);
        check("rst_beat", 32'(beat), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_match_over", 32'(match_over), 0);

        // go held high across release must not start a round
        @(negedge clk) sw2 = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("held_go_busy", 32'(busy), 0);
            check("held_go_pulse", 32'(start_pulse), 0);
        end

        do_round(3'b001, 3'b010, 3'b001, 3'b010, 1'b0, 3'd0, 16);
        do_round(3'b011, 3'b000, 3'b011, 3'b000, 1'b0, 3'd0, 16);
        do_round(3'b100, 3'b001, 3'b010, 3'b100, 1'b1, 3'd0, 16);
        repeat (4) begin
            @(posedge clk); #1;
            check("post_ignore_busy", 32'(busy), 0);
            check("post_ignore_pulse", 32'(start_pulse), 0);
            check("post_ignore_left", 32'(left), 32'(3'b100));
        end

        do_round(3'b001, 3'b100, 3'b001, 3'b100, 1'b0, 3'd3, 16);
        for (int i = 0; i < 20; i++) begin
            go = (i % 2 == 0);
            @(posedge clk); #1;
            check("done_match_over", 32'(match_over), 1);
            check("done_pulse", 32'(start_pulse), 0);
            check("done_busy", 32'(busy), 0);
        end
        go = 1'b0;
        sw2 = 1'b1;
        #1;
        check("clr_match_over", 32'(match_over), 0);
        @(negedge clk) sw2 = 1'b0;
        a_score = 3'd0;

        // Reset half a cycle after the pulse rises
        do_round(3'b010, 3'b100, 3'b010, 3'b100, 1'b0, 3'd0, 13);
        #4;
        sw2 = 1'b1;
        #1;
        check("abort_pulse", 32'(start_pulse), 0);
        check("abort_left", 32'(left), 0);
        check("abort_right", 32'(right), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_beat", 32'(beat), 0);
        #9;
        sw2 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_abort_busy", 32'(busy), 0);
            check("post_abort_pulse", 32'(start_pulse), 0);
        end

        do_round(3'b111, 3'b001, 3'b111, 3'b001, 1'b0, 3'd0, 16);
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gesture_issuer.md
# gesture_issuer

Front-end round sequencer that drives the score grader. On a player "go" it runs a three-beat countdown, samples both players' gesture buttons at the end of the countdown, and presents one-hot `left`/`right` gesture codes with a clean `start_pulse` to the grader. It then reads back `a_score`/`b_score` and stops issuing rounds once either player reaches the winning score.

## Interface

Parameters:
- `BEAT_CYCLES`, default 50_000_000: clock cycles per countdown beat. The bench uses 4.
- `PULSE_CYCLES`, default 2: width of `start_pulse`, in cycles. Must be ≥1.
- `WIN_SCORE`, default 3: score that ends the match, compared as unsigned 3-bit.

Ports (one clock; reset is asynchronous and active-high, named `sw2` as in the rest of the design):
- `clk`  in  1  system clock, rising-edge.
- `sw2`  in  1  async active-high reset / clear.
- `go`  in  1  round request, level; a rising edge is detected internally.
- `btn_left`  in  3  left player buttons, intended one-hot.
- `btn_right`  in  3  right player buttons, intended one-hot.
- `a_score`  in  3  grader score for left.
- `b_score`  in  3  grader score for right.
- `left`  out  3  registered left gesture to grader: 001/010/100, or 000 for no valid show.
- `right`  out  3  registered right gesture, same encoding.
- `start_pulse`  out  1  grader strobe, registered.
- `beat`  out  2  countdown display value: 3, 2, 1, 0.
- `busy`  out  1  high from COUNT through SETTLE.
- `match_over`  out  1  high in DONE.

## Operation

- States: IDLE, COUNT, SETUP, PULSE, SETTLE, DONE.
- Reset (`sw2`=1) is asynchronous and takes effect mid-anything:
  - state=IDLE; `left`=`right`=000; `start_pulse`=0; `beat`=0; `busy`=0; `match_over`=0.
  - Beat and pulse counters clear to 0.
  - `go_d` resets to 1, so `go` held high across reset release does not start a round.
- Edge detect: `go_edge` = `go` & ~`go_d`. `go_d` is registered every cycle in every state.
- IDLE:
  - On `go_edge`, go to COUNT with `beat`=3 and the beat counter at 0.
  - `left`/`right` hold their last values.
- COUNT:
  - The beat counter increments each cycle.
  - At BEAT_CYCLES−1 it wraps to 0 and `beat` decrements.
  - When `beat` goes 1→0, on the same edge: state goes to SETUP and both gestures are latched.
- Gesture latch:
  - `left` ← `btn_left` if it has exactly one bit set, else 000. `right` uses the same rule.
  - 000, 011 and 111 all latch 000.
- SETUP: lasts 1 cycle and gives the grader setup margin. Next state is PULSE with `start_pulse`←1.
- PULSE:
  - `start_pulse` stays high for exactly PULSE_CYCLES cycles, then drops to 0.
  - Next state is SETTLE.
- SETTLE: lasts 1 cycle. At its closing edge:
  - If `a_score`≥WIN_SCORE or `b_score`≥WIN_SCORE, go to DONE.
  - Otherwise go to IDLE.
- DONE:
  - `match_over`=1.
  - `go` is ignored and outputs hold.
  - Exit only via `sw2`.
- `go_edge` in COUNT, SETUP, PULSE or SETTLE is discarded, not queued.
- Button changes outside the latch edge never affect `left`/`right`.
- Beat counter width: clog2(BEAT_CYCLES), minimum 1 bit.

## Timing

Let E be the rising edge at which `go`=1 and `go_d`=0 are sampled in IDLE.

- E: `busy`=1, `beat`=3.
- Beat edges (with BEAT_CYCLES=B):
  - E+B: `beat`=2.
  - E+2B: `beat`=1.
  - E+3B: `beat`=0; `left`/`right` valid; state SETUP.
- E+3B+1: `start_pulse` rises.
- E+3B+1+PULSE_CYCLES: `start_pulse` falls; state SETTLE.
- E+3B+2+PULSE_CYCLES: scores are sampled, `busy` falls, and `match_over` rises if the win check passes.
- Round latency is 3B+PULSE_CYCLES+2 cycles; with the bench parameters it is 16.
- `left`/`right` are stable from one cycle before the `start_pulse` rise until at least the next round's latch edge.
- Earliest next round: a `go_edge` sampled at the edge after `busy` falls.

## Test plan

Bench parameters: B=4, PULSE_CYCLES=2, WIN_SCORE=3.

- **Reset release with go held:** hold `go`=1 through `sw2` 1→0 -> all outputs 0, `busy` stays 0; dropping `go` and raising it again starts a round.
- **Valid round:** `btn_left`=001, `btn_right`=010, go edge at E -> `beat` reads 3/2/1/0 at E/E+4/E+8/E+12; `left`=001 and `right`=010 from E+12; `start_pulse` high E+13..E+14; `busy` low at E+16.
- **Invalid shows:** `btn_left`=011, `btn_right`=000 at the latch edge -> `left`=000, `right`=000, `start_pulse` still issued.
- **Ignored inputs:** second go edge at E+5 and button changes during PULSE -> no extra round, `left`/`right` unchanged, exactly one 2-cycle `start_pulse`.
- **Match end:** `a_score`=3 at SETTLE -> `match_over`=1 at E+16; later go edges produce no `start_pulse`; `sw2` clears `match_over` to 0.
- **Reset mid-round:** `sw2` asserted at E+13.5, during the pulse -> `start_pulse` drops to 0 immediately (asynchronous), `left`=`right`=000, `busy`=0, state IDLE after release.
